// File: rtl/uop_xor_arbiter.sv
// Round-robin arbiter time-sharing one W-bit gate-level XOR among N requesters; 2-cycle req-to-y_valid latency.
// One operation per 3 cycles; req is sampled only in IDLE, so requesters hold req/operands until their gnt pulse.
module uop_xor_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     y_out,
  output logic             y_valid,
  output logic [IDW-1:0]   y_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   y_q, y_d;
  logic           yv_q, yv_d;
  logic [IDW-1:0] yid_q, yid_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;

  // Shared datapath: each bit is the two-inverter / two-AND / one-OR XOR cell.
  logic [W-1:0] a_n, b_n, t_ab, t_ba, xor_y;

  for (genvar i = 0; i < W; i++) begin : g_xor_cell
    assign a_n[i]   = ~opa_q[i];
    assign b_n[i]   = ~opb_q[i];
    assign t_ab[i]  = opa_q[i] & b_n[i];
    assign t_ba[i]  = a_n[i] & opb_q[i];
    assign xor_y[i] = t_ab[i] | t_ba[i];
  end

  // First set request at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % N]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    id_d    = id_q;
    gnt_d   = '0;
    y_d     = y_q;
    yv_d    = 1'b0;
    yid_d   = yid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          opa_d          = a_in[int'(win_idx)*W +: W];
          opb_d          = b_in[int'(win_idx)*W +: W];
          id_d           = win_idx;
          gnt_d[win_idx] = 1'b1;
          state_d        = CALC;
        end
      end
      CALC: begin
        y_d     = xor_y;
        yid_d   = id_q;
        yv_d    = 1'b1;
        ptr_d   = (int'(id_q) == N - 1) ? '0 : id_q + 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      yid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      yid_q   <= yid_d;
    end
  end

  assign gnt     = gnt_q;
  assign y_out   = y_q;
  assign y_valid = yv_q;
  assign y_id    = yid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uop_xor_arbiter.sv
// Directed plus randomized checks of uop_xor_arbiter against a round-robin reference model.
module tb_uop_xor_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   a_in = '0;
  logic [N*W-1:0]   b_in = '0;
  logic [N-1:0]     gnt;
  logic [W-1:0]     y_out;
  logic             y_valid;
  logic [IDW-1:0]   y_id;
  logic             busy;

  uop_xor_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .y_out(y_out), .y_valid(y_valid), .y_id(y_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_vld_cyc = -100;
  int model_ptr = 0;
  logic [W-1:0] last_y = '0;
  int last_id = 0;
  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < N; k++) begin
      a_in[k*W +: W] = a_arr[k];
      b_in[k*W +: W] = b_arr[k];
    end
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N; k++) begin
      a_arr[k] = W'($urandom);
      b_arr[k] = W'($urandom);
    end
    pack();
  endtask

  // Reference: first requesting index at or after the pointer, scanning upward with wrap.
  function automatic int model_winner(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(model_ptr + i) % N]) return (model_ptr + i) % N;
    end
    return -1;
  endfunction

  // Called in an IDLE cycle; returns in the following IDLE cycle.
  task automatic run_op(input logic [N-1:0] r, input bit scramble, input bit drop, input bit chk_gap);
    int k;
    logic [W-1:0] ey;
    req = r;
    pack();
    k = model_winner(r);
    ey = a_arr[k] ^ b_arr[k];
    tick();
    check("gnt_calc", 32'(gnt), 32'(1) << k);
    check("busy_calc", 32'(busy), 32'(1));
    check("vld_calc", 32'(y_valid), 32'(0));
    if (scramble) begin
      rand_ops();
      req = '0;
    end
    tick();
    check("y_valid", 32'(y_valid), 32'(1));
    check("y_out", 32'(y_out), 32'(ey));
    check("y_id", 32'(y_id), 32'(k));
    check("gnt_done", 32'(gnt), 32'(0));
    check("busy_done", 32'(busy), 32'(1));
    if (chk_gap) check("vld_spacing", 32'(cyc - last_vld_cyc), 32'(3));
    last_vld_cyc = cyc;
    model_ptr = (k + 1) % N;
    last_y = ey;
    last_id = k;
    if (drop) req = '0;
    tick();
    check("busy_idle", 32'(busy), 32'(0));
    check("vld_idle", 32'(y_valid), 32'(0));
    check("y_hold", 32'(y_out), 32'(ey));
    check("yid_hold", 32'(y_id), 32'(k));
  endtask

  initial begin
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) begin
      a_arr[k] = '0;
      b_arr[k] = '0;
    end
    pack();
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_y", 32'(y_out), 32'(0));
    check("rst_vld", 32'(y_valid), 32'(0));
    check("rst_id", 32'(y_id), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;

    a_arr[0] = 8'hA5;
    b_arr[0] = 8'h0F;
    run_op(4'b0001, 1'b0, 1'b1, 1'b0);
    check("t1_y_aa", 32'(y_out), 32'hAA);

    // Reset again so the continuous-request run starts at pointer 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_ptr = 0;
    check("rst2_y", 32'(y_out), 32'(0));
    tick();

    for (int k = 0; k < N; k++) begin
      a_arr[k] = W'(8'h11 * (k + 1));
      b_arr[k] = 8'hFF;
    end
    for (int n = 0; n < 5; n++) run_op(4'b1111, 1'b0, 1'b0, n > 0);
    check("rr_last_id", 32'(y_id), 32'(0));
    check("rr_last_y", 32'(y_out), 32'hEE);

    run_op(4'b1000, 1'b0, 1'b1, 1'b0);
    run_op(4'b1001, 1'b0, 1'b1, 1'b0);
    check("wrap_id0", 32'(y_id), 32'(0));
    run_op(4'b1001, 1'b0, 1'b1, 1'b0);
    check("wrap_ptr1_id3", 32'(y_id), 32'(3));

    rand_ops();
    run_op(4'b0100, 1'b1, 1'b1, 1'b0);
    check("scr_id2", 32'(y_id), 32'(2));

    // Abort an operation in CALC.
    req = 4'b0100;
    pack();
    tick();
    check("abort_gnt_calc", 32'(gnt), 32'h4);
    reset = 1'b1;
    tick();
    check("abort_gnt", 32'(gnt), 32'(0));
    check("abort_vld", 32'(y_valid), 32'(0));
    check("abort_y", 32'(y_out), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    req = '0;
    tick();
    check("abort_vld2", 32'(y_valid), 32'(0));
    tick();
    check("abort_vld3", 32'(y_valid), 32'(0));
    model_ptr = 0;
    last_y = '0;
    last_id = 0;
    run_op(4'b1111, 1'b0, 1'b1, 1'b0);
    check("abort_next_id0", 32'(y_id), 32'(0));

    a_arr[1] = 8'hFF;
    b_arr[1] = 8'hFF;
    run_op(4'b0010, 1'b0, 1'b1, 1'b0);
    check("bnd_ff_ff", 32'(y_out), 32'h00);
    a_arr[1] = 8'h00;
    b_arr[1] = 8'hFF;
    run_op(4'b0010, 1'b0, 1'b1, 1'b0);
    check("bnd_00_ff", 32'(y_out), 32'hFF);

    for (int n = 0; n < 60; n++) begin
      r = N'($urandom);
      rand_ops();
      if (r == '0) begin
        req = '0;
        tick();
        check("rnd_idle_busy", 32'(busy), 32'(0));
        check("rnd_idle_gnt", 32'(gnt), 32'(0));
        check("rnd_idle_vld", 32'(y_valid), 32'(0));
        check("rnd_idle_y", 32'(y_out), 32'(last_y));
        check("rnd_idle_id", 32'(y_id), 32'(last_id));
      end else begin
        run_op(r, 1'($urandom), 1'($urandom), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
